// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the DRAM controller slice: default geometry and id widths,
// command encodings driven onto the command bus, and the sequencer state enum.
package dram_ctrl_pkg;

  localparam int unsigned NumOfBanks = 8;
  localparam int unsigned NumOfRows  = 128;
  localparam int unsigned NumOfCols  = 8;
  localparam int unsigned BankIdW    = 3;
  localparam int unsigned RowIdW     = 7;
  localparam int unsigned ColIdW     = 3;

  typedef enum logic [1:0] {
    CMD_PRE = 2'b00,
    CMD_ACT = 2'b01,
    CMD_RD  = 2'b10,
    CMD_WR  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StDecide,
    StIssue,
    StRelease,
    StDone
  } seq_state_e;

endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank open-row bookkeeping: one {open, row} entry per bank.
// Ports:
//   clk_i, rst_ni      clock; synchronous active-low clear of all entries (all banks closed)
//   lookup_bank_i      bank to look up (combinational)
//   lookup_open_o      bank currently has an open row
//   lookup_row_o       row that is open in that bank
//   set_i, clr_i       open (with upd_row_i) / close bank upd_bank_i at the next edge
//   upd_bank_i         bank to update
//   upd_row_i          row recorded on set
module dram_open_row_table #(
  parameter int unsigned NumBanks = 8,
  parameter int unsigned BankIdW  = 3,
  parameter int unsigned RowIdW   = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [BankIdW-1:0] lookup_bank_i,
  output logic               lookup_open_o,
  output logic [RowIdW-1:0]  lookup_row_o,
  input  logic               set_i,
  input  logic               clr_i,
  input  logic [BankIdW-1:0] upd_bank_i,
  input  logic [RowIdW-1:0]  upd_row_i
);

  logic [NumBanks-1:0] open_q;
  logic [RowIdW-1:0]   row_q [NumBanks];

  // Ids beyond the bank count read as closed and never update the table.
  always_comb begin
    lookup_open_o = 1'b0;
    lookup_row_o  = '0;
    if (32'(lookup_bank_i) < NumBanks) begin
      lookup_open_o = open_q[lookup_bank_i];
      lookup_row_o  = row_q[lookup_bank_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      open_q <= '0;
      for (int unsigned i = 0; i < NumBanks; i++) begin
        row_q[i] <= '0;
      end
    end else if (32'(upd_bank_i) < NumBanks) begin
      if (clr_i) begin
        open_q[upd_bank_i] <= 1'b0;
      end else if (set_i) begin
        open_q[upd_bank_i] <= 1'b1;
        row_q[upd_bank_i]  <= upd_row_i;
      end
    end
  end

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Turns one decoded request into its PRE/ACT/RD/WR command sequence, issued over a
// four-phase cmd_req/cmd_ack handshake; row hits skip PRE/ACT.
// Ports:
//   clk, rst_b                    clock; synchronous active-low reset
//   req_valid/req_ready           request handshake (ready only when idle and out of reset)
//   req_rw, req_*_id              request fields (1=write), latched on accept
//   cmd_req/cmd_ack               four-phase command handshake
//   cmd, cmd_*_id                 command code and ids, stable while cmd_req is high
//   done, row_hit                 one-cycle completion pulse; row_hit valid with done
module dram_cmd_sequencer
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_OF_BANKS = NumOfBanks,
  parameter int unsigned BANK_ID_W    = BankIdW,
  parameter int unsigned ROW_ID_W     = RowIdW,
  parameter int unsigned COL_ID_W     = ColIdW
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rw,
  input  logic [BANK_ID_W-1:0] req_bank_id,
  input  logic [ROW_ID_W-1:0]  req_row_id,
  input  logic [COL_ID_W-1:0]  req_col_id,
  output logic                 cmd_req,
  output logic [1:0]           cmd,
  output logic [BANK_ID_W-1:0] cmd_bank_id,
  output logic [ROW_ID_W-1:0]  cmd_row_id,
  output logic [COL_ID_W-1:0]  cmd_col_id,
  input  logic                 cmd_ack,
  output logic                 done,
  output logic                 row_hit
);

  seq_state_e           state_q, state_d;
  logic                 rw_q, rw_d;
  logic [BANK_ID_W-1:0] bank_q, bank_d;
  logic [ROW_ID_W-1:0]  row_q, row_d;
  logic [COL_ID_W-1:0]  col_q, col_d;
  logic                 hit_q, hit_d;
  logic                 cmd_req_q, cmd_req_d;
  cmd_e                 cmd_q, cmd_d;
  logic [BANK_ID_W-1:0] cmd_bank_q, cmd_bank_d;
  logic [ROW_ID_W-1:0]  cmd_row_q, cmd_row_d;
  logic [COL_ID_W-1:0]  cmd_col_q, cmd_col_d;
  logic                 done_q, done_d;
  logic                 row_hit_q, row_hit_d;

  logic                 tbl_open;
  logic [ROW_ID_W-1:0]  tbl_row;
  logic                 tbl_set, tbl_clr;
  cmd_e                 access_cmd;

  dram_open_row_table #(
    .NumBanks (NUM_OF_BANKS),
    .BankIdW  (BANK_ID_W),
    .RowIdW   (ROW_ID_W)
  ) u_open_row_table (
    .clk_i         (clk),
    .rst_ni        (rst_b),
    .lookup_bank_i (bank_q),
    .lookup_open_o (tbl_open),
    .lookup_row_o  (tbl_row),
    .set_i         (tbl_set),
    .clr_i         (tbl_clr),
    .upd_bank_i    (bank_q),
    .upd_row_i     (row_q)
  );

  assign access_cmd = rw_q ? CMD_WR : CMD_RD;
  assign req_ready  = (state_q == StIdle) && rst_b;

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    bank_d     = bank_q;
    row_d      = row_q;
    col_d      = col_q;
    hit_d      = hit_q;
    cmd_req_d  = cmd_req_q;
    cmd_d      = cmd_q;
    cmd_bank_d = cmd_bank_q;
    cmd_row_d  = cmd_row_q;
    cmd_col_d  = cmd_col_q;
    done_d     = 1'b0;
    row_hit_d  = 1'b0;
    tbl_set    = 1'b0;
    tbl_clr    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rw_d    = req_rw;
          bank_d  = req_bank_id;
          row_d   = req_row_id;
          col_d   = req_col_id;
          state_d = StDecide;
        end
      end
      StDecide: begin
        hit_d = tbl_open && (tbl_row == row_q);
        if (hit_d) begin
          cmd_d = access_cmd;
        end else if (tbl_open) begin
          cmd_d = CMD_PRE;
        end else begin
          cmd_d = CMD_ACT;
        end
        // Every command carries the latched ids; the device picks what it needs.
        cmd_bank_d = bank_q;
        cmd_row_d  = row_q;
        cmd_col_d  = col_q;
        cmd_req_d  = 1'b1;
        state_d    = StIssue;
      end
      StIssue: begin
        if (cmd_ack) begin
          cmd_req_d = 1'b0;
          state_d   = StRelease;
        end
      end
      StRelease: begin
        if (!cmd_ack) begin
          tbl_clr = (cmd_q == CMD_PRE);
          tbl_set = (cmd_q == CMD_ACT);
          // The plan is a fixed tail PRE -> ACT -> access, so the command just
          // completed determines what follows.
          unique case (cmd_q)
            CMD_PRE: begin
              cmd_d     = CMD_ACT;
              cmd_req_d = 1'b1;
              state_d   = StIssue;
            end
            CMD_ACT: begin
              cmd_d     = access_cmd;
              cmd_req_d = 1'b1;
              state_d   = StIssue;
            end
            CMD_RD, CMD_WR: begin
              done_d    = 1'b1;
              row_hit_d = hit_q;
              state_d   = StDone;
            end
            default: state_d = StDone;
          endcase
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      rw_q       <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      hit_q      <= 1'b0;
      cmd_req_q  <= 1'b0;
      cmd_q      <= CMD_PRE;
      cmd_bank_q <= '0;
      cmd_row_q  <= '0;
      cmd_col_q  <= '0;
      done_q     <= 1'b0;
      row_hit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      hit_q      <= hit_d;
      cmd_req_q  <= cmd_req_d;
      cmd_q      <= cmd_d;
      cmd_bank_q <= cmd_bank_d;
      cmd_row_q  <= cmd_row_d;
      cmd_col_q  <= cmd_col_d;
      done_q     <= done_d;
      row_hit_q  <= row_hit_d;
    end
  end

  assign cmd_req     = cmd_req_q;
  assign cmd         = cmd_q;
  assign cmd_bank_id = cmd_bank_q;
  assign cmd_row_id  = cmd_row_q;
  assign cmd_col_id  = cmd_col_q;
  assign done        = done_q;
  assign row_hit     = row_hit_q;

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
module tb_dram_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [2:0] req_bank_id = '0;
  logic [6:0] req_row_id = '0;
  logic [2:0] req_col_id = '0;
  logic       cmd_req;
  logic [1:0] cmd;
  logic [2:0] cmd_bank_id;
  logic [6:0] cmd_row_id;
  logic [2:0] cmd_col_id;
  logic       cmd_ack = 1'b0;
  logic       done;
  logic       row_hit;

  int errors = 0;
  int checks = 0;

  // Reference state: which row (if any) each bank holds open.
  bit mopen [8];
  int mrow  [8];

  dram_cmd_sequencer dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rw      (req_rw),
    .req_bank_id (req_bank_id),
    .req_row_id  (req_row_id),
    .req_col_id  (req_col_id),
    .cmd_req     (cmd_req),
    .cmd         (cmd),
    .cmd_bank_id (cmd_bank_id),
    .cmd_row_id  (cmd_row_id),
    .cmd_col_id  (cmd_col_id),
    .cmd_ack     (cmd_ack),
    .done        (done),
    .row_hit     (row_hit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      mopen[i] = 1'b0;
      mrow[i]  = 0;
    end
  endtask

  task automatic present(input logic rw, input int b, input int r, input int c);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ready_before_req", req_ready, 1);
    req_valid   = 1'b1;
    req_rw      = rw;
    req_bank_id = 3'(b);
    req_row_id  = 7'(r);
    req_col_id  = 3'(c);
    tick();
    // Scramble fields after accept; the sequencer must use its latched copy.
    req_valid   = 1'b0;
    req_rw      = 1'($urandom);
    req_bank_id = 3'($urandom);
    req_row_id  = 7'($urandom);
    req_col_id  = 3'($urandom);
  endtask

  // Issues one request and plays the device side with per-command ack delay d
  // and ack hold h; latency from accept to done must be 1 + sum(d + h + 2).
  task automatic run_req(input logic rw, input int b, input int r, input int c,
                         input int dlo, input int dhi, input int hlo, input int hhi,
                         input bit stall);
    logic [1:0] exp_cmds[$];
    bit exp_hit;
    int lat, lat_exp, n, d, h;
    exp_hit = mopen[b] && (mrow[b] == r);
    if (!exp_hit) begin
      if (mopen[b]) exp_cmds.push_back(2'b00);
      exp_cmds.push_back(2'b01);
    end
    exp_cmds.push_back(rw ? 2'b11 : 2'b10);
    mopen[b] = 1'b1;
    mrow[b]  = r;

    present(rw, b, r, c);
    lat     = 0;
    lat_exp = 1;
    foreach (exp_cmds[i]) begin
      n = 0;
      while (cmd_req !== 1'b1 && n < 200) begin
        tick();
        lat++;
        n++;
      end
      check("cmd_req_rise", cmd_req, 1);
      if (cmd_req !== 1'b1) return;
      check("cmd_code", cmd, exp_cmds[i]);
      check("cmd_ids", {cmd_bank_id, cmd_row_id, cmd_col_id}, {3'(b), 7'(r), 3'(c)});
      d = (stall && i == 0) ? 50 : int'($urandom_range(dhi, dlo));
      h = int'($urandom_range(hhi, hlo));
      lat_exp += d + h + 2;
      for (int k = 0; k < d; k++) begin
        tick();
        lat++;
        check("hold_req", cmd_req, 1);
        check("hold_cmd", cmd, exp_cmds[i]);
        check("hold_ids", {cmd_bank_id, cmd_row_id, cmd_col_id}, {3'(b), 7'(r), 3'(c)});
        check("hold_ready", req_ready, 0);
      end
      cmd_ack = 1'b1;
      tick();
      lat++;
      check("cmd_req_fall", cmd_req, 0);
      for (int k = 0; k < h; k++) begin
        tick();
        lat++;
        check("release_req_low", cmd_req, 0);
      end
      cmd_ack = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      lat++;
      n++;
      check("no_extra_cmd", cmd_req, 0);
    end
    check("done", done, 1);
    check("row_hit", row_hit, exp_hit);
    check("latency", lat, lat_exp);
    tick();
    check("done_pulse", done, 0);
    check("ready_after_done", req_ready, 1);
  endtask

  initial begin
    int n;
    model_clear();

    // Reset state.
    tick();
    tick();
    tick();
    check("rst_cmd_req", cmd_req, 0);
    check("rst_cmd", cmd, 0);
    check("rst_ids", {cmd_bank_id, cmd_row_id, cmd_col_id}, 0);
    check("rst_done", done, 0);
    check("rst_row_hit", row_hit, 0);
    check("rst_ready", req_ready, 0);
    rst_b = 1'b1;
    #1;
    check("ready_out_of_rst", req_ready, 1);

    // Closed bank, hit, conflict, hit on new row.
    run_req(1'b0, 2, 5, 3, 2, 2, 0, 1, 1'b0);
    run_req(1'b1, 2, 5, 7, 2, 2, 0, 1, 1'b0);
    run_req(1'b0, 2, 9, 0, 2, 2, 0, 1, 1'b0);
    run_req(1'b0, 2, 9, 4, 0, 0, 0, 0, 1'b0);

    // Independent banks.
    run_req(1'b0, 0, 1, 1, 0, 3, 0, 2, 1'b0);
    run_req(1'b1, 7, 1, 2, 0, 3, 0, 2, 1'b0);
    run_req(1'b0, 0, 1, 6, 0, 3, 0, 2, 1'b0);

    // Long ack stall on the first command.
    run_req(1'b1, 3, 4, 5, 0, 1, 0, 1, 1'b1);

    // Reset while ACT is outstanding.
    present(1'b0, 5, 2, 1);
    n = 0;
    while (cmd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("rst_mid_req", cmd_req, 1);
    check("rst_mid_cmd", cmd, 2'b01);
    rst_b = 1'b0;
    tick();
    check("rst_mid_drop", cmd_req, 0);
    check("rst_mid_ready", req_ready, 0);
    check("rst_mid_done", done, 0);
    rst_b = 1'b1;
    #1;
    check("rst_mid_ready_rel", req_ready, 1);
    model_clear();
    run_req(1'b0, 2, 9, 3, 0, 2, 0, 1, 1'b0);

    // Randomized traffic over a small row range so hits and conflicts both occur.
    for (int t = 0; t < 40; t++) begin
      run_req(1'($urandom), int'($urandom_range(7)), int'($urandom_range(3)),
              int'($urandom_range(7)), 0, 3, 0, 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_cmd_sequencer.md
Name: dram_cmd_sequencer

Overview:
Downstream of the address translator, upstream of the DRAM device/BFM. Takes one decoded request at a time (bank/row/col plus read/write) and emits the PRECHARGE/ACTIVATE/READ/WRITE sequence that request needs. Commands go out over the controller's four-phase cmd_req/cmd_ack handshake. Tracks the open row per bank so row hits skip PRE/ACT.

Parameters:
NUM_OF_BANKS, 8, number of banks
NUM_OF_ROWS, 128, rows per bank
NUM_OF_COLS, 8, columns per row
BANK_ID_W, 3, log2(NUM_OF_BANKS)
ROW_ID_W, 7, log2(NUM_OF_ROWS)
COL_ID_W, 3, log2(NUM_OF_COLS)

Ports:
clk  in  1  clock, all logic on rising edge
rst_b  in  1  synchronous active-low reset
req_valid  in  1  decoded request present
req_ready  out  1  sequencer accepts request this cycle
req_rw  in  1  1=write, 0=read
req_bank_id  in  BANK_ID_W  target bank
req_row_id  in  ROW_ID_W  target row
req_col_id  in  COL_ID_W  target column
cmd_req  out  1  command request (four-phase)
cmd  out  2  00=PRE, 01=ACT, 10=RD, 11=WR
cmd_bank_id  out  BANK_ID_W  bank for cmd
cmd_row_id  out  ROW_ID_W  row for cmd (ACT; PRE/RD/WR carry latched row)
cmd_col_id  out  COL_ID_W  column for cmd (RD/WR; else latched col)
cmd_ack  in  1  command acknowledge, same clock domain
done  out  1  one-cycle pulse: request fully issued
row_hit  out  1  valid with done: request needed no PRE/ACT

Behaviour:
- Reset (rst_b=0 at an edge): state=IDLE; cmd_req=0; cmd=00; cmd_*_id=0; done=0; row_hit=0; all banks marked closed. req_ready=0 while rst_b=0.
- req_ready = (state==IDLE) && rst_b. Accept on req_valid && req_ready. Fields latched at the accept edge; inputs ignored afterwards.
- States: IDLE, DECIDE, ISSUE, RELEASE, DONE.
- IDLE: accept edge -> DECIDE.
- DECIDE (1 cycle): look up the bank entry {open, row}.
  - Hit (open && row==req_row): plan=ACCESS only; row_hit flag set.
  - Conflict (open && row!=req_row): plan=PRE, ACT, ACCESS.
  - Closed: plan=ACT, ACCESS.
  - ACCESS = RD if req_rw=0, WR if req_rw=1.
  - Next edge loads the first planned cmd and ids, sets cmd_req=1, -> ISSUE.
- ISSUE: cmd_req and all cmd_* held stable until cmd_ack=1 is sampled. That edge sets cmd_req=0, -> RELEASE. No timeout; an ack held low stalls indefinitely.
- RELEASE: wait for cmd_ack=0 sampled.
  - Then, if more cmds remain in the plan: the same edge loads the next cmd, cmd_req=1, -> ISSUE.
  - Otherwise -> DONE.
- Open-row table update at the RELEASE-exit edge:
  - PRE clears open[bank].
  - ACT sets open[bank]=1, row[bank]=req_row.
  - RD/WR: no change.
- DONE (1 cycle): done=1, row_hit=latched flag; next edge -> IDLE with done=0.
- Minimum latency, hit with ack returning in one cycle: accept edge E0, cmd_req rises E1, falls E2, RELEASE exits E3, done high E3–E4, ready again after E4.
- cmd_ack already high on entry to ISSUE: that is the ack, so cmd_req drops at the next edge. Ack low on entry to RELEASE: exits at the next edge.
- cmd_ack is ignored in IDLE, DECIDE and DONE.
- Reset mid-handshake: cmd_req=0 at the reset edge; the in-flight request is discarded; the table is cleared (all closed). The device side must be reset together.
- Bank/row/col ids are never wrapped or modified. Out-of-range ids (>= count) are not checked; they pass through unchanged.

Decomposition:
- dram_ctrl_pkg:
  - cmd encodings CMD_PRE/CMD_ACT/CMD_RD/CMD_WR
  - sequencer state enum
  - the ID width constants
- Sub-module dram_open_row_table:
  - NUM_OF_BANKS entries of {open, row}
  - combinational lookup by bank id
  - synchronous set/clear ports
  - synchronous clear-all on rst_b=0

Test Plan:
- Closed bank: after reset, read bank 2 row 5 col 3, ack 2 cycles after each req -> cmds ACT(b2,r5) then RD(b2,c3); done=1, row_hit=0.
- Hit: next, write bank 2 row 5 col 7 -> single WR(b2,c7); done with row_hit=1; no PRE/ACT issued.
- Conflict: next, read bank 2 row 9 col 0 -> PRE(b2), ACT(b2,r9), RD(b2,c0). Then bank 2 row 9 access is a hit.
- Independent banks: ACT b0 r1, then access b7 r1 -> b7 closed, so ACT+ACCESS. Then b0 r1 again is a hit.
- Stall: hold cmd_ack=0 for 50 cycles in ISSUE -> cmd_req stays 1, cmd/ids stable, req_ready=0; sequence completes normally once ack is given.
- Reset during ISSUE of ACT -> cmd_req=0 next edge, req_ready=1 after release. Prior hit row now misses (ACT issued).
